// File: rtl/debug_view_pkg.sv
// Shared types and the seven-segment glyph table for the board debug front-end.
// Glyphs are active low. Bit 0 drives segment a and bit 6 drives segment g.
package debug_view_pkg;

    typedef enum logic [1:0] {
        MODE_MANUAL = 2'b00,
        MODE_AUTO   = 2'b01,
        MODE_FREEZE = 2'b10,
        MODE_RSVD   = 2'b11
    } mode_t;

    // Each entry is written as {g,f,e,d,c,b,a}, so the digit 0 pattern (g off) is 7'h40.
    localparam logic [6:0] HEX_GLYPH [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30,
        7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03,
        7'h46, 7'h21, 7'h06, 7'h0E
    };

    function automatic logic [6:0] hex7(input logic [3:0] nibble);
        return HEX_GLYPH[nibble];
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Push-button conditioner. It is built from a 2-FF synchroniser, a stability counter and a
// falling-edge detector, and it gives one pulse per debounced press.
module key_debounce #(
    parameter int unsigned DEBOUNCE = 500_000
) (
    input  logic CLOCK_50,
    input  logic ResetN,
    input  logic key_n,
    output logic pulse
);

    localparam int unsigned CNT_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             level_q;
    logic             level_d;
    logic             levelPrev_q;
    logic             pulse_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Any agreement between the synchronised key and the debounced level restarts the count.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge CLOCK_50 or negedge ResetN) begin
        if (!ResetN) begin
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            level_q     <= 1'b1;
            levelPrev_q <= 1'b1;
            cnt_q       <= '0;
            pulse_q     <= 1'b0;
        end else begin
            sync1_q     <= key_n;
            sync2_q     <= sync1_q;
            level_q     <= level_d;
            cnt_q       <= cnt_d;
            levelPrev_q <= level_q;
            pulse_q     <= levelPrev_q & ~level_q;
        end
    end

    assign pulse = pulse_q;

endmodule

// File: rtl/debug_view_ctrl.sv
// Debug display front-end. It selects a channel by switch, by auto-rotation or by freeze,
// registers the chosen value and decodes it to active-low seven-segment digits.
module debug_view_ctrl
    import debug_view_pkg::*;
#(
    parameter int unsigned NUM_CH   = 8,
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned DIGITS   = DATA_W / 4,
    parameter int unsigned DEBOUNCE = 500_000,
    parameter int unsigned DWELL    = 50_000_000
) (
    input  logic                        CLOCK_50,
    input  logic                        ResetN,
    input  logic                        step_key_n,
    input  logic [1:0]                  mode,
    input  logic [$clog2(NUM_CH)-1:0]   sel,
    input  logic [NUM_CH*DATA_W-1:0]    ch_data,
    output logic                        step_pulse,
    output logic [$clog2(NUM_CH)-1:0]   cur_ch,
    output logic [DATA_W-1:0]           view,
    output logic [DIGITS*7-1:0]         hex_seg
);

    localparam int unsigned SEL_W   = $clog2(NUM_CH);
    localparam int unsigned DWELL_W = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [SEL_W-1:0]   LAST_CH    = SEL_W'(NUM_CH - 1);
    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL - 1);

    mode_t              modeSel;
    logic [SEL_W-1:0]   cur_q;
    logic [SEL_W-1:0]   cur_d;
    logic [DWELL_W-1:0] dwell_q;
    logic [DWELL_W-1:0] dwell_d;
    logic [DATA_W-1:0]  view_q;
    logic [DATA_W-1:0]  view_d;
    logic [DATA_W-1:0]  chArr [NUM_CH];

    key_debounce #(
        .DEBOUNCE (DEBOUNCE)
    ) u_step_key (
        .CLOCK_50 (CLOCK_50),
        .ResetN   (ResetN),
        .key_n    (step_key_n),
        .pulse    (step_pulse)
    );

    for (genvar k = 0; k < NUM_CH; k++) begin : g_unpack
        assign chArr[k] = ch_data[k*DATA_W +: DATA_W];
    end

    assign modeSel = mode_t'(mode);

    // Outside auto mode the dwell counter sits at 0. Re-entering auto therefore always starts a full dwell.
    always_comb begin
        cur_d   = cur_q;
        dwell_d = '0;
        view_d  = chArr[cur_q];
        case (modeSel)
            MODE_AUTO: begin
                if (dwell_q == DWELL_LAST) begin
                    cur_d = (cur_q == LAST_CH) ? '0 : cur_q + 1'b1;
                end else begin
                    dwell_d = dwell_q + 1'b1;
                end
            end
            MODE_FREEZE: begin
                view_d = view_q;
            end
            MODE_MANUAL, MODE_RSVD: begin
                cur_d = (sel > LAST_CH) ? LAST_CH : sel;
            end
            default: begin
                cur_d = (sel > LAST_CH) ? LAST_CH : sel;
            end
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge ResetN) begin
        if (!ResetN) begin
            cur_q   <= '0;
            dwell_q <= '0;
            view_q  <= '0;
        end else begin
            cur_q   <= cur_d;
            dwell_q <= dwell_d;
            view_q  <= view_d;
        end
    end

    for (genvar d = 0; d < DIGITS; d++) begin : g_digit
        assign hex_seg[d*7 +: 7] = hex7(view_q[d*4 +: 4]);
    end

    assign cur_ch = cur_q;
    assign view   = view_q;

endmodule

// File: tb/tb_debug_view_ctrl.sv
// Directed bench for debug_view_ctrl. It covers reset, debounce, manual, auto and freeze modes, and reset in mid-operation.
// A second instance with NUM_CH=3 checks the out-of-range select clamp.
module tb_debug_view_ctrl;

    localparam int NUM_CH   = 4;
    localparam int DATA_W   = 16;
    localparam int DEBOUNCE = 4;
    localparam int DWELL    = 3;

    logic CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    logic        ResetN;
    logic        step_key_n;
    logic [1:0]  mode;
    logic [1:0]  sel;
    logic [63:0] ch_data;
    logic        step_pulse;
    logic [1:0]  cur_ch;
    logic [15:0] view;
    logic [27:0] hex_seg;

    logic        key3;
    logic [1:0]  mode3;
    logic [1:0]  sel3;
    logic [47:0] ch_data3;
    logic        pulse3;
    logic [1:0]  cur3;
    logic [15:0] view3;
    logic [27:0] hex3;

    int nChecks = 0;
    int nPassed = 0;

    logic [15:0] chVals [4];

    debug_view_ctrl #(
        .NUM_CH(NUM_CH), .DATA_W(DATA_W), .DEBOUNCE(DEBOUNCE), .DWELL(DWELL)
    ) dut (
        .CLOCK_50(CLOCK_50), .ResetN(ResetN), .step_key_n(step_key_n), .mode(mode),
        .sel(sel), .ch_data(ch_data), .step_pulse(step_pulse), .cur_ch(cur_ch),
        .view(view), .hex_seg(hex_seg)
    );

    debug_view_ctrl #(
        .NUM_CH(3), .DATA_W(DATA_W), .DEBOUNCE(DEBOUNCE), .DWELL(DWELL)
    ) dut3 (
        .CLOCK_50(CLOCK_50), .ResetN(ResetN), .step_key_n(key3), .mode(mode3),
        .sel(sel3), .ch_data(ch_data3), .step_pulse(pulse3), .cur_ch(cur3),
        .view(view3), .hex_seg(hex3)
    );

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic set_channels(input logic [15:0] c3, input logic [15:0] c2,
                                input logic [15:0] c1, input logic [15:0] c0);
        chVals[0] = c0; chVals[1] = c1; chVals[2] = c2; chVals[3] = c3;
        ch_data = {c3, c2, c1, c0};
    endtask

    task automatic test_reset();
        ResetN = 1'b0; step_key_n = 1'b1; mode = 2'b01; sel = 2'd2;
        set_channels(16'hDDDD, 16'hCCCC, 16'hBBBB, 16'hAAAA);
        key3 = 1'b1; mode3 = 2'b00; sel3 = 2'd3; ch_data3 = {16'h3333, 16'h2222, 16'h1111};
        repeat (3) tick();
        nChecks++; if (step_pulse !== 1'b0) $display("[TB] FAIL reset_pulse: got %b expected 0", step_pulse); else nPassed++;
        nChecks++; if (cur_ch !== 2'd0) $display("[TB] FAIL reset_cur: got %0d expected 0", cur_ch); else nPassed++;
        nChecks++; if (view !== 16'h0000) $display("[TB] FAIL reset_view: got %h expected 0000", view); else nPassed++;
        for (int d = 0; d < 4; d++) begin
            nChecks++;
            if (hex_seg[d*7 +: 7] !== 7'h40) $display("[TB] FAIL reset_hex%0d: got %h expected 40", d, hex_seg[d*7 +: 7]);
            else nPassed++;
        end
        nChecks++; if (cur3 !== 2'd0) $display("[TB] FAIL reset_cur3: got %0d expected 0", cur3); else nPassed++;
        mode = 2'b00; sel = 2'd0;
        ResetN = 1'b1;
        tick();
    endtask

    task automatic test_debounce();
        step_key_n = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            tick();
            nChecks++; if (step_pulse !== 1'b0) $display("[TB] FAIL glitch_low%0d: got %b expected 0", k, step_pulse); else nPassed++;
        end
        step_key_n = 1'b1;
        tick();
        nChecks++; if (step_pulse !== 1'b0) $display("[TB] FAIL glitch_high: got %b expected 0", step_pulse); else nPassed++;
        step_key_n = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            nChecks++;
            if (step_pulse !== (k == 7)) $display("[TB] FAIL press_cycle%0d: got %b expected %b", k, step_pulse, (k == 7));
            else nPassed++;
        end
        step_key_n = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            nChecks++; if (step_pulse !== 1'b0) $display("[TB] FAIL release_cycle%0d: got %b expected 0", k, step_pulse); else nPassed++;
        end
    endtask

    task automatic test_manual();
        logic [6:0] glyph1234 [4];
        glyph1234[0] = 7'h19; glyph1234[1] = 7'h30; glyph1234[2] = 7'h24; glyph1234[3] = 7'h79;
        sel = 2'd2;
        tick();
        nChecks++; if (cur_ch !== 2'd2) $display("[TB] FAIL sel_cur: got %0d expected 2", cur_ch); else nPassed++;
        nChecks++; if (view !== 16'hAAAA) $display("[TB] FAIL sel_view_early: got %h expected AAAA", view); else nPassed++;
        tick();
        nChecks++; if (view !== 16'hCCCC) $display("[TB] FAIL sel_view: got %h expected CCCC", view); else nPassed++;
        for (int d = 0; d < 4; d++) begin
            nChecks++;
            if (hex_seg[d*7 +: 7] !== 7'h46) $display("[TB] FAIL hexC_%0d: got %h expected 46", d, hex_seg[d*7 +: 7]);
            else nPassed++;
        end
        sel = 2'd3;
        tick();
        nChecks++; if (cur_ch !== 2'd3) $display("[TB] FAIL sel3_cur: got %0d expected 3", cur_ch); else nPassed++;
        mode = 2'b11; sel = 2'd1;
        tick();
        nChecks++; if (cur_ch !== 2'd1) $display("[TB] FAIL rsvd_cur: got %0d expected 1", cur_ch); else nPassed++;
        mode = 2'b00; sel = 2'd3;
        tick();
        tick();
        nChecks++; if (view !== 16'hDDDD) $display("[TB] FAIL view_ch3: got %h expected DDDD", view); else nPassed++;
        nChecks++; if (hex_seg[6:0] !== 7'h21) $display("[TB] FAIL hexD: got %h expected 21", hex_seg[6:0]); else nPassed++;
        ch_data[63:48] = 16'h1234;
        tick();
        nChecks++; if (view !== 16'h1234) $display("[TB] FAIL data_follow: got %h expected 1234", view); else nPassed++;
        for (int d = 0; d < 4; d++) begin
            nChecks++;
            if (hex_seg[d*7 +: 7] !== glyph1234[d]) $display("[TB] FAIL hex1234_%0d: got %h expected %h", d, hex_seg[d*7 +: 7], glyph1234[d]);
            else nPassed++;
        end
        ch_data[63:48] = 16'hDDDD;
        tick();
        nChecks++; if (view !== 16'hDDDD) $display("[TB] FAIL data_restore: got %h expected DDDD", view); else nPassed++;
        nChecks++; if (cur3 !== 2'd2) $display("[TB] FAIL clamp_cur3: got %0d expected 2", cur3); else nPassed++;
        nChecks++; if (view3 !== 16'h3333) $display("[TB] FAIL clamp_view3: got %h expected 3333", view3); else nPassed++;
    endtask

    task automatic test_auto();
        int prevCur;
        int expCur;
        prevCur = 3;
        mode = 2'b01;
        sel = 2'd2;
        for (int k = 1; k <= 19; k++) begin
            tick();
            expCur = ((k / 3) + 3) % 4;
            nChecks++;
            if (cur_ch !== 2'(expCur)) $display("[TB] FAIL auto_cur%0d: got %0d expected %0d", k, cur_ch, expCur);
            else nPassed++;
            nChecks++;
            if (view !== chVals[prevCur]) $display("[TB] FAIL auto_view%0d: got %h expected %h", k, view, chVals[prevCur]);
            else nPassed++;
            prevCur = expCur;
        end
    endtask

    task automatic test_freeze();
        mode = 2'b10;
        set_channels(16'h4444, 16'h3333, 16'h2222, 16'h1111);
        for (int k = 1; k <= 20; k++) begin
            tick();
            nChecks++; if (view !== 16'hBBBB) $display("[TB] FAIL freeze_view%0d: got %h expected BBBB", k, view); else nPassed++;
            nChecks++; if (cur_ch !== 2'd1) $display("[TB] FAIL freeze_cur%0d: got %0d expected 1", k, cur_ch); else nPassed++;
        end
        step_key_n = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            nChecks++;
            if (step_pulse !== (k == 7)) $display("[TB] FAIL freeze_press%0d: got %b expected %b", k, step_pulse, (k == 7));
            else nPassed++;
        end
        step_key_n = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            nChecks++; if (step_pulse !== 1'b0) $display("[TB] FAIL freeze_release%0d: got %b expected 0", k, step_pulse); else nPassed++;
        end
        mode = 2'b00; sel = 2'd0;
        tick();
        nChecks++; if (cur_ch !== 2'd0) $display("[TB] FAIL unfreeze_cur: got %0d expected 0", cur_ch); else nPassed++;
        tick();
        nChecks++; if (view !== 16'h1111) $display("[TB] FAIL unfreeze_view: got %h expected 1111", view); else nPassed++;
    endtask

    task automatic test_mode_on_wrap();
        mode = 2'b01;
        tick();
        tick();
        mode = 2'b10;
        tick();
        nChecks++; if (cur_ch !== 2'd0) $display("[TB] FAIL wrap_leave_cur: got %0d expected 0", cur_ch); else nPassed++;
        mode = 2'b01;
        tick();
        tick();
        nChecks++; if (cur_ch !== 2'd0) $display("[TB] FAIL reentry_hold: got %0d expected 0", cur_ch); else nPassed++;
        tick();
        nChecks++; if (cur_ch !== 2'd1) $display("[TB] FAIL reentry_step: got %0d expected 1", cur_ch); else nPassed++;
    endtask

    task automatic test_reset_mid();
        ResetN = 1'b0;
        tick();
        set_channels(16'hDDDD, 16'hCCCC, 16'hBBBB, 16'hAAAA);
        mode = 2'b01;
        step_key_n = 1'b1;
        ResetN = 1'b1;
        tick();
        tick();
        step_key_n = 1'b0;
        repeat (4) tick();
        nChecks++; if (cur_ch !== 2'd2) $display("[TB] FAIL mid_setup_cur: got %0d expected 2", cur_ch); else nPassed++;
        ResetN = 1'b0;
        #1;
        nChecks++; if (cur_ch !== 2'd0) $display("[TB] FAIL mid_reset_cur: got %0d expected 0", cur_ch); else nPassed++;
        nChecks++; if (view !== 16'h0000) $display("[TB] FAIL mid_reset_view: got %h expected 0000", view); else nPassed++;
        nChecks++; if (hex_seg[6:0] !== 7'h40) $display("[TB] FAIL mid_reset_hex: got %h expected 40", hex_seg[6:0]); else nPassed++;
        for (int k = 1; k <= 3; k++) begin
            tick();
            nChecks++; if (step_pulse !== 1'b0) $display("[TB] FAIL in_reset_pulse%0d: got %b expected 0", k, step_pulse); else nPassed++;
        end
        ResetN = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (k == 1) begin
                nChecks++; if (cur_ch !== 2'd0) $display("[TB] FAIL post_reset_cur: got %0d expected 0", cur_ch); else nPassed++;
            end
            nChecks++;
            if (step_pulse !== (k == DEBOUNCE + 3)) $display("[TB] FAIL held_key_cycle%0d: got %b expected %b", k, step_pulse, (k == DEBOUNCE + 3));
            else nPassed++;
        end
        step_key_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_debounce();
        test_manual();
        test_auto();
        test_freeze();
        test_mode_on_wrap();
        test_reset_mid();
        $display("%0d/%0d checks passed", nPassed, nChecks);
        $finish;
    end

endmodule

// File: doc/debug_view_ctrl.md
# debug_view_ctrl

Parametrised debug front-end for the board-level processor build: conditions a raw push-button into a debounced single-cycle step pulse and selects one of NUM_CH debug channels for display on DIGITS seven-segment digits. It adds auto-rotate and freeze display modes to plain switch selection. It sits between the board I/O (KEY/SW/HEX) and the processor's debug buses in the top-level wrapper.

## Interface
Parameters:
- NUM_CH, 8: number of debug channels; must be ≥ 2.
- DATA_W, 16: channel width; must be a multiple of 4.
- DIGITS, DATA_W/4: hex digits driven. Derived; do not override.
- DEBOUNCE, 500_000: cycles the synchronised key must stay stable before the debounced level changes; must be ≥ 1.
- DWELL, 50_000_000: cycles each channel is shown in auto mode; must be ≥ 1.

Ports:
- CLOCK_50, in, 1: the one clock. Everything is synchronous to its rising edge.
- ResetN, in, 1: asynchronous, active-low reset.
- step_key_n, in, 1: raw push-button, low = pressed. Asynchronous.
- mode, in, 2: 00 manual, 01 auto-rotate, 10 freeze, 11 reserved (behaves as manual).
- sel, in, $clog2(NUM_CH): manual channel select.
- ch_data, in, NUM_CH*DATA_W: flattened channels; channel k is bits [k*DATA_W +: DATA_W].
- step_pulse, out, 1: one-cycle pulse on each debounced press.
- cur_ch, out, $clog2(NUM_CH): channel currently selected.
- view, out, DATA_W: registered displayed value.
- hex_seg, out, DIGITS*7: active-low segments. Digit d is bits [d*7 +: 7] and shows view nibble d. Within a digit, index 0 = segment a through index 6 = segment g.

## Operation
- Key path: 2-FF synchroniser, then a stability counter. The counter resets on any change of the synchronised level relative to the debounced level. Once it reaches DEBOUNCE, the debounced level takes the synchronised value and the counter clears.
- step_pulse: high for exactly one cycle when the debounced level goes 1→0. A release never pulses, and a held key produces exactly one pulse.
- Manual mode: cur_ch <= sel every cycle. If sel ≥ NUM_CH, cur_ch clamps to NUM_CH-1.
- Auto mode:
  - Dwell counter counts 0..DWELL-1. At DWELL-1 it returns to 0 and cur_ch increments.
  - cur_ch wraps from NUM_CH-1 to 0. sel is ignored.
  - On entry to auto from any other mode, the dwell counter clears and rotation starts from the existing cur_ch.
- Freeze mode: cur_ch and view hold. The dwell counter holds at 0. step_pulse generation continues.
- view <= ch_data[cur_ch] every cycle, except in freeze.
- hex_seg: combinational decode of view using the standard 0–F glyphs: 0=0000001, 1=1001111, …, F=0111000.
- Reset values:
  - step_pulse 0, cur_ch 0, view 0.
  - hex_seg = 0000001 on every digit.
  - Debounced level 1 (released), synchroniser flops 1, all counters 0.

## Timing
- Latency, sel → cur_ch: 1 cycle. sel → view/hex_seg: 2 cycles.
- ch_data change → view: 1 cycle, when not frozen.
- Key press → step_pulse: 2 synchroniser cycles + DEBOUNCE cycles + 1 register cycle. The bench checks the exact cycle.
- Bounce shorter than DEBOUNCE cycles in either direction causes no level change and no pulse.
- Auto mode: cur_ch changes exactly every DWELL cycles. With DWELL=1 it advances every cycle.
- Mode changes on the same edge as a dwell wrap: the new mode wins, so there is no increment when leaving auto.
- Freeze→manual: cur_ch follows sel on the next cycle.
- ResetN asserted mid-debounce or mid-dwell: all state clears immediately, with no pulse during or after reset while the key stays released.
- Key held across reset deassertion: produces one pulse, DEBOUNCE+3 cycles after release of reset.

## Structure
- Package debug_view_pkg holds:
  - mode_t enum: MODE_MANUAL, MODE_AUTO, MODE_FREEZE, MODE_RSVD.
  - Constant array HEX_GLYPH[16] of 7-bit active-low patterns.
  - Function hex7(nibble).
- Sub-module key_debounce(CLOCK_50, ResetN, key_n, pulse) with parameter DEBOUNCE. It contains the synchroniser, stability counter and edge detect, and is reused for other board keys.
- Top of the block: mode/dwell/cur_ch logic, view register, generate loop over DIGITS for hex7.

## Test plan
Bench parameters: NUM_CH=4, DATA_W=16, DEBOUNCE=4, DWELL=3.
- Reset: ResetN=0 with arbitrary inputs → cur_ch=0, view=0x0000, each hex_seg digit=0000001, step_pulse=0.
- Debounce: key low 3 cycles, high, then low 10 cycles → no pulse from the glitch. Exactly one step_pulse, 7 cycles after the stable low starts. No pulse on release.
- Manual select:
  - ch_data = {0xDDDD, 0xCCCC, 0xBBBB, 0xAAAA}, mode=00, sel=2 → view=0xCCCC and hex_seg digits all = C glyph after 2 cycles.
  - With 2-bit sel every value is in range, so verify the sel ≥ NUM_CH clamp at NUM_CH=3: sel=3 → cur_ch=2.
- Auto rotate: mode=01 from cur_ch=3 → cur_ch sequence 3,0,1,2, each held 3 cycles. The view sequence follows one cycle later.
- Freeze: in auto at cur_ch=1, view=0xBBBB, set mode=10 and change all ch_data → view stays 0xBBBB for 20 cycles. A key press still gives one step_pulse.
- Reset mid-operation: assert ResetN during a held key at counter=2 and in auto at cur_ch=2 → immediate return to reset values. After release, cur_ch restarts at 0 and one pulse occurs DEBOUNCE+3 cycles later.
